// File: rtl/branch_sched_pkg.sv
// -----------------------------------------------------------------------------
// branch_sched_pkg
// Shared types and constants for the D-stage branch scheduler.
//   cmpop_e      : branch comparison selector (CMPOP_SIZE bits)
//   opnd_t       : operand lookup result {pending, data}
//   SB_E/M/W     : scoreboard slot indices, youngest first
// -----------------------------------------------------------------------------
package branch_sched_pkg;

    localparam int CMPOP_SIZE  = 3;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 32;
    localparam int TNEW_W_DFLT = 2;

    localparam int SB_DEPTH = 3;
    localparam int SB_E     = 0;
    localparam int SB_M     = 1;
    localparam int SB_W     = 2;

    // CMPOP_NOP and the reserved code both evaluate true.
    typedef enum logic [CMPOP_SIZE-1:0] {
        CMPOP_NOP  = 3'd0,
        CMPOP_EQ   = 3'd1,
        CMPOP_NE   = 3'd2,
        CMPOP_LT   = 3'd3,
        CMPOP_LE   = 3'd4,
        CMPOP_GT   = 3'd5,
        CMPOP_GE   = 3'd6,
        CMPOP_RSVD = 3'd7
    } cmpop_e;

    typedef struct packed {
        logic              pending;
        logic [DATA_W-1:0] data;
    } opnd_t;

endpackage

// File: rtl/branch_sched_if.sv
// -----------------------------------------------------------------------------
// branch_sched_if
// Bundles the branch request, issue, forwarding and redirect signals.
//   master : drives the branch/issue/forward inputs, observes stall/taken/pc
//   slave  : the scheduler side
// -----------------------------------------------------------------------------
import branch_sched_pkg::*;

interface branch_sched_if #(
    parameter int TNEW_W = TNEW_W_DFLT
);
    logic              br_valid;
    cmpop_e            br_op;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_grf;
    logic [DATA_W-1:0] rt_grf;
    logic [DATA_W-1:0] br_target;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic [TNEW_W-1:0] iss_tnew;
    logic [DATA_W-1:0] fwd_e;
    logic [DATA_W-1:0] fwd_m;
    logic [DATA_W-1:0] fwd_w;
    logic              stall;
    logic              taken;
    logic [DATA_W-1:0] redirect_pc;

    modport master (
        output br_valid, br_op, rs_addr, rt_addr, rs_grf, rt_grf, br_target,
               iss_valid, iss_addr, iss_tnew, fwd_e, fwd_m, fwd_w,
        input  stall, taken, redirect_pc
    );

    modport slave (
        input  br_valid, br_op, rs_addr, rt_addr, rs_grf, rt_grf, br_target,
               iss_valid, iss_addr, iss_tnew, fwd_e, fwd_m, fwd_w,
        output stall, taken, redirect_pc
    );
endinterface

// File: rtl/branch_sched_cmp.sv
// -----------------------------------------------------------------------------
// branch_sched_cmp
// Combinational branch comparator (signed ordering compares).
//   i_op     : comparison selector
//   i_a/i_b  : forwarded rs/rt operands
//   o_result : 1 when the condition holds; NOP/reserved codes give 1
// -----------------------------------------------------------------------------
module branch_sched_cmp
    import branch_sched_pkg::*;
(
    input  cmpop_e            i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_result
);
    logic w_eq;
    logic w_lt;

    assign w_eq = (i_a == i_b);
    assign w_lt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_result = 1'b1;
        case (i_op)
            CMPOP_EQ: o_result = w_eq;
            CMPOP_NE: o_result = ~w_eq;
            CMPOP_LT: o_result = w_lt;
            CMPOP_LE: o_result = w_lt | w_eq;
            CMPOP_GT: o_result = ~(w_lt | w_eq);
            CMPOP_GE: o_result = ~w_lt;
            default:  o_result = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_sched.sv
// -----------------------------------------------------------------------------
// branch_sched
// D-stage branch scheduler. Tracks in-flight GPR writes in an E/M/W
// scoreboard, stalls a branch until both operands are forwardable, picks the
// forwarded operands and resolves the branch in its own D cycle.
//   clk    : system clock
//   reset  : synchronous, active-high; clears the scoreboard
//   bus    : branch_sched_if.slave (branch, issue, forwarding, redirect)
// -----------------------------------------------------------------------------
module branch_sched
    import branch_sched_pkg::*;
#(
    parameter int TNEW_W = TNEW_W_DFLT
) (
    input  logic         clk,
    input  logic         reset,
    branch_sched_if.slave bus
);
    logic [SB_DEPTH-1:0]             r_sb_v;
    logic [SB_DEPTH-1:0][ADDR_W-1:0] r_sb_addr;
    logic [SB_DEPTH-1:0][TNEW_W-1:0] r_sb_tnew;

    logic [SB_DEPTH-1:0][DATA_W-1:0] w_fwd;
    opnd_t                           w_rs;
    opnd_t                           w_rt;
    logic                            w_stall;
    logic                            w_cmp_res;
    logic                            w_taken;

    assign w_fwd[SB_E] = bus.fwd_e;
    assign w_fwd[SB_M] = bus.fwd_m;
    assign w_fwd[SB_W] = bus.fwd_w;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // Scan oldest to youngest so the youngest matching writer wins.
    function automatic opnd_t lookup(input logic [ADDR_W-1:0] a,
                                     input logic [DATA_W-1:0] grf);
        opnd_t res;
        res.pending = 1'b0;
        res.data    = grf;
        if (a != '0) begin
            for (int s = SB_DEPTH - 1; s >= 0; s--) begin
                if (r_sb_v[s] && (r_sb_addr[s] == a)) begin
                    res.pending = (r_sb_tnew[s] != '0);
                    res.data    = w_fwd[s];
                end
            end
        end
        return res;
    endfunction

    assign w_rs = lookup(bus.rs_addr, bus.rs_grf);
    // Same register on both ports must resolve identically.
    assign w_rt = (bus.rt_addr == bus.rs_addr) ? w_rs
                                               : lookup(bus.rt_addr, bus.rt_grf);

    assign w_stall = ~reset & bus.br_valid & (w_rs.pending | w_rt.pending);

    branch_sched_cmp u_cmp (
        .i_op     (bus.br_op),
        .i_a      (w_rs.data),
        .i_b      (w_rt.data),
        .o_result (w_cmp_res)
    );

    assign w_taken         = ~reset & bus.br_valid & ~w_stall & w_cmp_res;
    assign bus.stall       = w_stall;
    assign bus.taken       = w_taken;
    assign bus.redirect_pc = w_taken ? bus.br_target : '0;

    // The scoreboard always advances; a stall only turns the E slot into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_v    <= '0;
            r_sb_addr <= '0;
            r_sb_tnew <= '0;
        end else begin
            if (w_stall) begin
                r_sb_v[SB_E]    <= 1'b0;
                r_sb_addr[SB_E] <= '0;
                r_sb_tnew[SB_E] <= '0;
            end else begin
                r_sb_v[SB_E]    <= bus.iss_valid & (bus.iss_addr != '0);
                r_sb_addr[SB_E] <= bus.iss_addr;
                r_sb_tnew[SB_E] <= bus.iss_tnew;
            end
            r_sb_v[SB_M]    <= r_sb_v[SB_E];
            r_sb_addr[SB_M] <= r_sb_addr[SB_E];
            r_sb_tnew[SB_M] <= sat_dec(r_sb_tnew[SB_E]);
            r_sb_v[SB_W]    <= r_sb_v[SB_M];
            r_sb_addr[SB_W] <= r_sb_addr[SB_M];
            r_sb_tnew[SB_W] <= sat_dec(r_sb_tnew[SB_M]);
        end
    end
endmodule
